// File: rtl/bin_to_bcd_seq.sv
// Sequential sign-magnitude binary to packed BCD converter (shift-add-3, one bit per clock).
// Optional macro BCD_SAT_EN: saturate bcd_out to all-9s when the magnitude overflows DIGITS digits.

module bin_to_bcd_add3 (
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);
   // A nibble that will reach >=10 after the next doubling is pre-biased by 3 (max result 4'b1100).
   assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module bin_to_bcd_seq #(
   parameter int W_MAG  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [W_MAG:0]        bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  sign_out,
   output logic                  ovf
);
   // One extra scratch digit catches magnitudes beyond the displayable range.
   localparam int SD = DIGITS + 1;
   localparam int SW = 4 * SD;
   localparam int CW = $clog2(W_MAG + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [W_MAG-1:0]     shift_q, shift_d;
   logic [SW-1:0]        scratch_q, scratch_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sign_q, sign_d;
   logic                 done_q, done_d;
   logic [4*DIGITS-1:0]  bcd_q, bcd_d;
   logic                 sign_out_q, sign_out_d;
   logic                 ovf_q, ovf_d;

   logic [SW-1:0]        scratch_adj;
   logic                 ovf_det;
   logic [4*DIGITS-1:0]  bcd_res;

   for (genvar g = 0; g < SD; g++) begin : g_nib
      bin_to_bcd_add3 u_add3 (
         .nib_i (scratch_q[4*g +: 4]),
         .nib_o (scratch_adj[4*g +: 4])
      );
   end

   assign ovf_det = |scratch_q[SW-1:4*DIGITS];

`ifdef BCD_SAT_EN
   assign bcd_res = ovf_det ? {DIGITS{4'h9}} : scratch_q[4*DIGITS-1:0];
`else
   assign bcd_res = scratch_q[4*DIGITS-1:0];
`endif

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      done_d     = 1'b0;
      bcd_d      = bcd_q;
      sign_out_d = sign_out_q;
      ovf_d      = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d   = bin_in[W_MAG-1:0];
               sign_d    = bin_in[W_MAG];
               scratch_d = '0;
               cnt_d     = CW'(W_MAG);
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scratch_d = {scratch_adj[SW-2:0], shift_q[W_MAG-1]};
            shift_d   = {shift_q[W_MAG-2:0], 1'b0};
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            bcd_d      = bcd_res;
            // Negative zero is reported as positive.
            sign_out_d = sign_q & (|scratch_q);
            ovf_d      = ovf_det;
            done_d     = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         sign_out_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         done_q     <= done_d;
         bcd_q      <= bcd_d;
         sign_out_q <= sign_out_d;
         ovf_q      <= ovf_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign sign_out = sign_out_q;
   assign ovf      = ovf_q;

endmodule
